// File: rtl/os_tx_scheduler_if.sv
// Handshake bundle between the TX LTSSM, the OS generator, the TX datapath mux and the scheduler.
// Latency: none (wires only).
// Backpressure: carried by OSGeneratorBusy/Finish and HoldFIFOData; the scheduler uses modport master.
interface os_tx_scheduler_if;
  logic       LtssmReq;
  logic [2:0] LtssmOSType;
  logic       LtssmDone;
  logic       DataMode;
  logic       SkpTimerEn;
  logic [2:0] OSType;
  logic       OSGeneratorStart;
  logic       OSGeneratorBusy;
  logic       OSGeneratorFinish;
  logic       MuxSel;
  logic       HoldFIFOData;
  logic [1:0] SkpPending;
  logic       SkpOverflow;

  // Scheduler side.
  modport master (
    input  LtssmReq, LtssmOSType, DataMode, SkpTimerEn, OSGeneratorBusy, OSGeneratorFinish,
    output LtssmDone, OSType, OSGeneratorStart, MuxSel, HoldFIFOData, SkpPending, SkpOverflow
  );

  // Surrounding logic side (LTSSM, generator, datapath).
  modport slave (
    output LtssmReq, LtssmOSType, DataMode, SkpTimerEn, OSGeneratorBusy, OSGeneratorFinish,
    input  LtssmDone, OSType, OSGeneratorStart, MuxSel, HoldFIFOData, SkpPending, SkpOverflow
  );
endinterface

// File: rtl/os_tx_scheduler.sv
// Shares the TX OS generator between LTSSM requests and periodic SKP (SKP logic under OS_SCHED_SKP_EN).
// Latency: request seen in cycle N -> OSGeneratorStart in N+1; every output is registered.
// Backpressure: no grant while OSGeneratorBusy; LPIF FIFO held whenever the OS path owns the mux.
module os_tx_scheduler #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_CNT_W    = 12,
  parameter int MAX_PEND     = 2
) (
  input  logic               Pclk,
  input  logic               Reset,
  os_tx_scheduler_if.master  ifc
);

  localparam logic [2:0] OS_SKP = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_DRAIN} state_t;

  state_t     state_q, state_d;
  logic       src_ltssm_q, src_ltssm_d;   // 1: OS in flight belongs to the LTSSM, 0: SKP
  logic [2:0] os_type_q, os_type_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       mux_sel_q, mux_sel_d;
  logic       hold_q, hold_d;
  logic [1:0] skp_pend_q;
  logic       skp_ovf_q;

`ifdef OS_SCHED_SKP_EN
  localparam logic [SKP_CNT_W-1:0] CNT_LAST = SKP_CNT_W'(SKP_INTERVAL - 1);
  localparam logic [1:0]           PEND_MAX = 2'(MAX_PEND);

  logic [SKP_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           skp_pend_d;
  logic                 skp_ovf_d;
  logic                 tick;
  logic                 skp_fin;

  // An SKP retires only on a finish that arrives while we are waiting on an SKP.
  assign skp_fin = (state_q == S_WAIT) && ifc.OSGeneratorFinish && !src_ltssm_q;

  // Interval counter and SKP queue; a tick coinciding with an SKP finish nets to no change.
  always_comb begin
    cnt_d      = cnt_q;
    skp_pend_d = skp_pend_q;
    skp_ovf_d  = skp_ovf_q;
    tick       = 1'b0;
    if (!ifc.SkpTimerEn) begin
      cnt_d      = '0;
      skp_pend_d = '0;
    end else begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && !skp_fin) begin
        if (skp_pend_q == PEND_MAX) begin
          skp_ovf_d = 1'b1;
        end else begin
          skp_pend_d = skp_pend_q + 2'd1;
        end
      end else if (skp_fin && !tick && (skp_pend_q != 2'd0)) begin
        // The queue may have been cleared by SkpTimerEn while this SKP was in flight.
        skp_pend_d = skp_pend_q - 2'd1;
      end
    end
  end

  // SKP counter/queue registers; overflow is sticky until reset.
  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      cnt_q      <= '0;
      skp_pend_q <= '0;
      skp_ovf_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      skp_pend_q <= skp_pend_d;
      skp_ovf_q  <= skp_ovf_d;
    end
  end
`else
  // Without SKP insertion the queue is permanently empty and the timer inputs are ignored.
  assign skp_pend_q = 2'd0;
  assign skp_ovf_q  = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{SKP_INTERVAL, SKP_CNT_W, MAX_PEND, ifc.SkpTimerEn};
`endif

  // Next state and next registered outputs; outputs always describe the state being entered.
  always_comb begin
    state_d     = state_q;
    src_ltssm_d = src_ltssm_q;
    os_type_d   = os_type_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    mux_sel_d   = mux_sel_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE: begin
        mux_sel_d = 1'b0;
        hold_d    = 1'b1;
        if (!ifc.OSGeneratorBusy) begin
          if (skp_pend_q != 2'd0) begin
            os_type_d   = OS_SKP;
            start_d     = 1'b1;
            src_ltssm_d = 1'b0;
            state_d     = S_WAIT;
          end else if (ifc.LtssmReq && !done_q) begin
            // While Done is high the LTSSM has not yet had a chance to drop the request it
            // just had serviced, so it must not be granted a second time.
            os_type_d   = ifc.LtssmOSType;
            start_d     = 1'b1;
            src_ltssm_d = 1'b1;
            state_d     = S_WAIT;
          end else if (ifc.DataMode) begin
            mux_sel_d = 1'b1;
            hold_d    = 1'b0;
            state_d   = S_DATA;
          end
        end
      end
      S_WAIT: begin
        mux_sel_d = 1'b0;
        hold_d    = 1'b1;
        if (ifc.OSGeneratorFinish) begin
          done_d  = src_ltssm_q;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        mux_sel_d = 1'b1;
        hold_d    = 1'b0;
        if (skp_pend_q != 2'd0) begin
          hold_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (!ifc.DataMode) begin
          mux_sel_d = 1'b0;
          hold_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        // One cycle with the mux still on data lets the in-flight datapath word leave.
        mux_sel_d = 1'b0;
        hold_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs; reset aborts any OS in flight without a Done.
  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      src_ltssm_q <= 1'b0;
      os_type_q   <= 3'd0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      mux_sel_q   <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_ltssm_q <= src_ltssm_d;
      os_type_q   <= os_type_d;
      start_q     <= start_d;
      done_q      <= done_d;
      mux_sel_q   <= mux_sel_d;
      hold_q      <= hold_d;
    end
  end

  assign ifc.OSType           = os_type_q;
  assign ifc.OSGeneratorStart = start_q;
  assign ifc.LtssmDone        = done_q;
  assign ifc.MuxSel           = mux_sel_q;
  assign ifc.HoldFIFOData     = hold_q;
  assign ifc.SkpPending       = skp_pend_q;
  assign ifc.SkpOverflow      = skp_ovf_q;

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Scoreboard bench for os_tx_scheduler: stimulus pushes expected events, a monitor pops and compares.
// Latency: expected cycles derived from the one-cycle grant rule and the generator model below.
// Backpressure: generator busy/finish modelled in-bench, plus forced busy windows from stimulus.
module tb_os_tx_scheduler;

`ifdef OS_SCHED_SKP_EN
  localparam int SKP_ON = 1;
`else
  localparam int SKP_ON = 0;
`endif

  localparam int EV_START  = 0;
  localparam int EV_DONE   = 1;
  localparam int EV_MUX_UP = 2;
  localparam int EV_MUX_DN = 3;

  typedef struct {
    int         kind;
    logic [2:0] ost;
    int         cyc;   // -1: any cycle
  } ev_t;

  logic Pclk;
  logic Reset;
  logic gen_busy;
  logic force_busy;
  int   cyc;
  int   checks;
  int   errors;
  int   start_cnt;
  int   done_cnt;
  int   gen_fin_cyc;
  ev_t  exp_q[$];

  os_tx_scheduler_if bus();

  assign bus.OSGeneratorBusy = gen_busy | force_busy;

  os_tx_scheduler #(.SKP_INTERVAL(16), .SKP_CNT_W(5), .MAX_PEND(2)) dut (
    .Pclk (Pclk),
    .Reset(Reset),
    .ifc  (bus)
  );

  initial begin
    Pclk = 1'b0;
    forever #5 Pclk = ~Pclk;
  end

  initial cyc = 0;
  always @(posedge Pclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int kind, input logic [2:0] t, input int c);
    ev_t e;
    e.kind = kind;
    e.ost  = t;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic logic [9:0] out_vec();
    return {bus.OSType, bus.OSGeneratorStart, bus.LtssmDone, bus.MuxSel,
            bus.HoldFIFOData, bus.SkpPending, bus.SkpOverflow};
  endfunction

  // Monitor: pops one expected event per observed DUT event.
  task automatic check_event(input string nm, input int kind, input logic [2:0] t);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind=%0d type=%0d at cyc=%0d", nm, kind, t, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || ((kind == EV_START || kind == EV_DONE) && e.ost != t) ||
          (e.cyc >= 0 && e.cyc != cyc)) begin
        errors++;
        $display("FAIL %s: got kind=%0d type=%0d cyc=%0d want kind=%0d type=%0d cyc=%0d",
                 nm, kind, t, cyc, e.kind, e.ost, e.cyc);
      end
    end
  endtask

  initial begin : monitor
    logic prev_mux;
    prev_mux = 1'b0;
    forever begin
      @(negedge Pclk);
      if (!Reset) begin
        prev_mux = 1'b0;
        continue;
      end
      if (bus.MuxSel != prev_mux) begin
        check_event("mux_edge", bus.MuxSel ? EV_MUX_UP : EV_MUX_DN, 3'd0);
        chk("hold_vs_mux", int'(bus.HoldFIFOData), int'(!bus.MuxSel));
        prev_mux = bus.MuxSel;
      end
      if (bus.OSGeneratorStart) begin
        start_cnt++;
        check_event("start", EV_START, bus.OSType);
      end
      if (bus.LtssmDone) begin
        done_cnt++;
        check_event("done", EV_DONE, bus.OSType);
        chk("done_latency", cyc, gen_fin_cyc + 1);
      end
    end
  end

  // OS generator model: busy for a random number of cycles after a start, then a finish pulse.
  initial begin : generator
    gen_busy = 1'b0;
    bus.OSGeneratorFinish = 1'b0;
    gen_fin_cyc = -10;
    forever begin
      @(negedge Pclk);
      if (Reset && bus.OSGeneratorStart) begin
        int lat;
        lat = $urandom_range(1, 4);
        step();
        gen_busy = 1'b1;
        repeat (lat - 1) step();
        step();
        bus.OSGeneratorFinish = 1'b1;
        gen_fin_cyc = cyc;
        step();
        bus.OSGeneratorFinish = 1'b0;
        gen_busy = 1'b0;
      end
    end
  end

  // Waits for LtssmDone, scrambling LtssmOSType once the grant has happened, then drops the request.
  task automatic wait_done(input int done0, input int start0);
    int n;
    n = 0;
    while (done_cnt == done0 && n < 60) begin
      step();
      n++;
      if (start_cnt > start0) bus.LtssmOSType = 3'($urandom);
    end
    chk("done_arrived", int'(done_cnt != done0), 1);
    bus.LtssmReq = 1'b0;
  endtask

  task automatic do_ltssm(input logic [2:0] t, input int busy_cyc);
    int k;
    int d0;
    int s0;
    k  = cyc;
    d0 = done_cnt;
    s0 = start_cnt;
    bus.LtssmOSType = t;
    bus.LtssmReq    = 1'b1;
    force_busy      = (busy_cyc > 0);
    push(EV_START, t, k + busy_cyc + 1);
    push(EV_DONE, t, -1);
    if (busy_cyc > 0) begin
      go_to(k + busy_cyc);
      force_busy = 1'b0;
    end
    wait_done(d0, s0);
  endtask

  task automatic do_drop_before_grant(input int d);
    int k;
    k = cyc;
    force_busy      = 1'b1;
    bus.LtssmOSType = 3'($urandom);
    bus.LtssmReq    = 1'b1;
    go_to(k + d);
    bus.LtssmReq = 1'b0;
    step();
    force_busy = 1'b0;
  endtask

  task automatic do_data(input int len, input bit defer);
    int k;
    int m;
    int d0;
    int s0;
    logic [2:0] t;
    k = cyc;
    t = 3'($urandom);
    bus.DataMode = 1'b1;
    push(EV_MUX_UP, 3'd0, k + 1);
    step();
    d0 = done_cnt;
    s0 = start_cnt;
    if (defer) begin
      bus.LtssmOSType = t;
      bus.LtssmReq    = 1'b1;
    end
    go_to(k + len);
    m = cyc;
    bus.DataMode = 1'b0;
    push(EV_MUX_DN, 3'd0, m + 1);
    if (defer) begin
      push(EV_START, t, m + 2);
      push(EV_DONE, t, -1);
      wait_done(d0, s0);
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (2) step();
    while (gen_busy && n < 20) begin
      step();
      n++;
    end
    repeat ($urandom_range(1, 3)) step();
  endtask

  initial begin : stimulus
    int k;
    int d0;
    int s0;
    logic [2:0] t;
    checks = 0;
    errors = 0;
    start_cnt = 0;
    done_cnt = 0;
    force_busy = 1'b0;
    Reset = 1'b0;
    bus.LtssmReq = 1'b0;
    bus.LtssmOSType = 3'd0;
    bus.DataMode = 1'b0;
    bus.SkpTimerEn = 1'b0;
    repeat (3) step();
    chk("reset_outputs", int'(out_vec()), 10'h008);
    Reset = 1'b1;
    repeat (2) step();
    chk("post_reset_outputs", int'(out_vec()), 10'h008);

    // Directed single LTSSM request, type 001.
    do_ltssm(3'b001, 0);
    settle();

    // Randomized mix of LTSSM requests, busy stalls, withdrawn requests and data bursts.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: do_ltssm(3'($urandom), 0);
        1: do_ltssm(3'($urandom), $urandom_range(1, 3));
        2: do_drop_before_grant($urandom_range(1, 3));
        default: do_data($urandom_range(2, 8), 1'($urandom));
      endcase
      settle();
    end

    // SKP interval: 16 cycles of SkpTimerEn queue one SKP which is then sent.
    k = cyc;
    bus.SkpTimerEn = 1'b1;
    if (SKP_ON != 0) push(EV_START, 3'b011, k + 17);
    go_to(k + 16);
    chk("skp_pending_after_interval", int'(bus.SkpPending), SKP_ON);
    go_to(k + 24);
    chk("skp_pending_after_finish", int'(bus.SkpPending), 0);
    bus.SkpTimerEn = 1'b0;
    settle();

    // Pending SKP and LTSSM request together: SKP wins, LTSSM follows.
    k  = cyc;
    d0 = done_cnt;
    s0 = start_cnt;
    t  = 3'b010;
    force_busy      = 1'b1;
    bus.SkpTimerEn  = 1'b1;
    bus.LtssmOSType = t;
    bus.LtssmReq    = 1'b1;
    if (SKP_ON != 0) begin
      push(EV_START, 3'b011, k + 18);
      push(EV_START, t, -1);
    end else begin
      push(EV_START, t, k + 18);
    end
    push(EV_DONE, t, -1);
    go_to(k + 17);
    force_busy = 1'b0;
    fork
      begin
        go_to(k + 25);
        bus.SkpTimerEn = 1'b0;
      end
      wait_done(d0, s0 + SKP_ON);
    join
    settle();

`ifdef OS_SCHED_SKP_EN
    // SKP tick during data: one drain cycle, SKP sent, then back to data.
    k = cyc;
    bus.DataMode   = 1'b1;
    bus.SkpTimerEn = 1'b1;
    push(EV_MUX_UP, 3'd0, k + 1);
    push(EV_MUX_DN, 3'd0, k + 18);
    push(EV_START, 3'b011, k + 19);
    push(EV_MUX_UP, 3'd0, -1);
    go_to(k + 17);
    chk("drain_mux_hold", int'({bus.MuxSel, bus.HoldFIFOData}), 3);
    go_to(k + 27);
    bus.SkpTimerEn = 1'b0;
    step();
    bus.DataMode = 1'b0;
    push(EV_MUX_DN, 3'd0, k + 29);
    settle();
`endif

    // Busy held across three ticks: queue saturates and overflow sticks after disable.
    k = cyc;
    force_busy     = 1'b1;
    bus.SkpTimerEn = 1'b1;
    go_to(k + 48);
    chk("skp_pending_saturated", int'(bus.SkpPending), 2 * SKP_ON);
    chk("skp_overflow_set", int'(bus.SkpOverflow), SKP_ON);
    bus.SkpTimerEn = 1'b0;
    step();
    chk("skp_pending_cleared", int'(bus.SkpPending), 0);
    chk("skp_overflow_sticky", int'(bus.SkpOverflow), SKP_ON);
    force_busy = 1'b0;
    settle();

    // Reset while waiting on an LTSSM OS: outputs reset at once, no Done afterwards.
    k  = cyc;
    d0 = done_cnt;
    bus.LtssmOSType = 3'b101;
    bus.LtssmReq    = 1'b1;
    push(EV_START, 3'b101, k + 1);
    go_to(k + 2);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_reset_outputs", int'(out_vec()), 10'h008);
    exp_q.delete();
    bus.LtssmReq = 1'b0;
    repeat (2) step();
    Reset = 1'b1;
    repeat (12) step();
    chk("no_done_after_reset", done_cnt, d0);
    chk("final_outputs", int'(out_vec()), 10'h008);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
